seq_shifter: RTL and testbench
==============================

# seq_shifter

Parametrised multi-cycle shift unit for the ALU datapath: the successor to the single-mode left shifter. It loads an N-bit operand on a start request and performs a programmable number of one-bit shifts, one per enabled clock. Modes are logical left/right, arithmetic right and rotate left/right. A busy/done handshake lets the ALU sequencer launch an operation and collect the result and carry-out.

## Interface
- N, 8, operand width; power of two, ≥ 2
- AW, $clog2(N), width of the shift-amount port (derived; do not override)
- clock  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  operation request, honoured only in IDLE
- mode  input  3  000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101–111 reserved
- amount  input  AW  number of one-bit shifts, 0..N-1
- in  input  N  operand
- en  input  1  shift enable; 0 stalls an operation in progress
- out  output  N  working/result register
- carry  output  1  last bit shifted out (rotate: last bit wrapped)
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse in DONE

## Operation
- All outputs are registered. Reset values: out=0, carry=0, busy=0, done=0, state=IDLE.
- Reset is synchronous and has priority over everything, including mid-operation. The cycle after a reset edge shows the reset values, and any in-flight operation is discarded.
- FSM states:
  - **IDLE.** If start=1, latch mode, load out←in and cnt←amount, clear carry, go to SHIFT. en is ignored for capture. start=0 keeps IDLE.
  - **SHIFT.** busy=1.
    - cnt==0 → go to DONE.
    - Else, if en=1, apply one shift step and cnt←cnt−1.
    - Else (en=0) hold out, carry and cnt.
  - **DONE.** done=1 and busy=0 for exactly one cycle, then go to IDLE.
- Shift steps:
  - LSL: out←{out[N-2:0],0}, carry←out[N-1].
  - LSR: out←{0,out[N-1:1]}, carry←out[0].
  - ASR: out←{out[N-1],out[N-1:1]}, carry←out[0].
  - ROL: out←{out[N-2:0],out[N-1]}, carry←out[N-1].
  - ROR: out←{out[0],out[N-1:1]}, carry←out[0].
  - Reserved modes: out unchanged, carry←0, cnt still decrements, so latency is identical.
- mode, amount and in are sampled only at the start-capture edge. Later changes have no effect on the running operation.
- start in SHIFT or DONE is ignored and not queued.
- out and carry hold their final values through DONE and IDLE until the next capture.
- amount=0: no shift step. out=in, carry=0.

## Timing
- Edge E0 samples start in IDLE. The cycle after E0 has busy=1 and out=in.
- With en held high, edges E1..Ek perform the k=amount shifts. Edge E(k+1) enters DONE.
- done is high in the cycle after E(k+1). Latency from capture edge to done pulse is amount+1 edges; total occupancy is amount+2 cycles.
- Each stalled cycle (en=0 in SHIFT with cnt>0) adds exactly one cycle of latency.
- en=0 when cnt==0 does not stall the SHIFT→DONE transition.
- The earliest back-to-back start is sampled in the IDLE cycle after done, so there is no new capture during DONE.
- busy and done are never high together.
- out changes visibly during SHIFT, one step per enabled cycle. Consumers use out only when done=1 or busy=0.

## Test plan
- N=4, LSL, in=1010, amount=1, en=1:
  - busy for 2 cycles, then done.
  - Final out=0100, carry=1.
- N=4, ASR, in=1010, amount=3:
  - Intermediate out values 1101, 1110, 1111.
  - Final out=1111, carry=0, done 4 edges after capture.
- N=4, ROL, in=1001, amount=3 → final out=1100, carry=0.
- N=4, ROR, in=1010, amount=1 → final out=0101, carry=0.
- Stall test, LSR, in=1000, amount=2:
  - Drop en for 3 cycles after the first shift, then raise it.
  - out holds at 0100 during the stall, final out=0010.
  - done arrives 3 cycles later than the unstalled run.
- Boundary test, three sub-cases:
  - amount=0: out=in, carry=0, done 1 edge after capture.
  - start pulsed while busy: ignored, result unchanged.
  - reset asserted mid-SHIFT: next cycle out=0, busy=0, done=0, carry=0, and a fresh start works normally.

Source files
------------

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift unit. Captures an operand on start, then
// performs one 1-bit shift (LSL/LSR/ASR/ROL/ROR) per enabled clock until the
// programmed amount is exhausted, and pulses done for one cycle.
//
// Handshake: start_i is a request that is accepted only while the unit is idle
// (busy_o=0 and done_o=0). A request seen during SHIFT or DONE is dropped, not
// queued. done_o is a single-cycle pulse with no back-pressure; out_o/carry_o
// hold the result from the done pulse until the next accepted start.
module seq_shifter #(
  parameter int N = 8,
  localparam int AW = $clog2(N)
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [2:0]    mode_i,
  input  logic [AW-1:0] amount_i,
  input  logic [N-1:0]  in_i,
  input  logic          en_i,
  output logic [N-1:0]  out_o,
  output logic          carry_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [1:0]    state_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2:0] MODE_LSL = 3'b000;
  localparam logic [2:0] MODE_LSR = 3'b001;
  localparam logic [2:0] MODE_ASR = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  logic [1:0]    state_q, state_d;
  logic [2:0]    mode_q, mode_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  out_q, out_d;
  logic          carry_q, carry_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [N-1:0]  step_out;
  logic          step_carry;

  // One shift step of the working register under the latched mode.
  always_comb begin
    step_out   = out_q;
    step_carry = 1'b0;
    case (mode_q)
      MODE_LSL: begin
        step_out   = {out_q[N-2:0], 1'b0};
        step_carry = out_q[N-1];
      end
      MODE_LSR: begin
        step_out   = {1'b0, out_q[N-1:1]};
        step_carry = out_q[0];
      end
      MODE_ASR: begin
        step_out   = {out_q[N-1], out_q[N-1:1]};
        step_carry = out_q[0];
      end
      MODE_ROL: begin
        step_out   = {out_q[N-2:0], out_q[N-1]};
        step_carry = out_q[N-1];
      end
      MODE_ROR: begin
        step_out   = {out_q[0], out_q[N-1:1]};
        step_carry = out_q[0];
      end
      // Reserved modes leave the operand alone and report no carry, while the
      // counter still runs so the latency matches the defined modes.
      default: begin
        step_out   = out_q;
        step_carry = 1'b0;
      end
    endcase
  end

  // FSM next state, datapath next values and registered status flags.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    carry_d = carry_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mode_d  = mode_i;
          cnt_d   = amount_i;
          out_d   = in_i;
          carry_d = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // An exhausted count finishes regardless of en_i.
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else if (en_i) begin
          out_d   = step_out;
          carry_d = step_carry;
          cnt_d   = cnt_q - AW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers; synchronous reset wins over everything.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_o   = out_q;
  assign carry_o = carry_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter at N=4: per-cycle trace checks against a
// small step model, final results from a scoreboard queue filled at launch.
module tb_seq_shifter;

  localparam int N  = 4;
  localparam int AW = 2;

  // ---------------------------------------------------------------- clock/reset
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    mode  = '0;
  logic [AW-1:0] amount = '0;
  logic [N-1:0]  din   = '0;
  logic          en    = 1'b1;
  logic [N-1:0]  out_o;
  logic          carry_o, busy_o, done_o;
  logic [1:0]    state_o;

  always #5 clock = ~clock;

  seq_shifter #(.N(N)) dut (
    .clock_i (clock),
    .reset_i (reset),
    .start_i (start),
    .mode_i  (mode),
    .amount_i(amount),
    .in_i    (din),
    .en_i    (en),
    .out_o   (out_o),
    .carry_o (carry_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .state_o (state_o)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [N:0] exp_q[$];   // {out, carry}
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference single step, written from the mode table.
  function automatic logic [N:0] model_step(input logic [2:0] md, input logic [N-1:0] v);
    case (md)
      3'b000:  return {v[2:0], 1'b0, v[3]};
      3'b001:  return {1'b0, v[3:1], v[0]};
      3'b010:  return {v[3], v[3:1], v[0]};
      3'b011:  return {v[2:0], v[3], v[3]};
      3'b100:  return {v[0], v[3:1], v[0]};
      default: return {v, 1'b0};
    endcase
  endfunction

  // ---------------------------------------------------------------- drivers
  // Launch one operation and follow it to the done pulse. stall_at/stall_len
  // drop en for stall_len cycles starting at that cycle count after capture;
  // poke_at pulses start at that cycle count (should be ignored).
  task automatic run_op(input string name, input logic [2:0] md, input logic [AW-1:0] amt,
                        input logic [N-1:0] v, input logic [N-1:0] exp_out, input logic exp_c,
                        input int exp_lat, input int stall_at, input int stall_len,
                        input int poke_at);
    logic [N-1:0] m_out;
    logic         m_carry;
    logic [N:0]   nxt;
    logic [N:0]   exp_r;
    int           m_cnt;
    int           edges;
    int           busy_cycles;
    @(negedge clock);
    start = 1'b1; mode = md; amount = amt; din = v; en = 1'b1;
    @(negedge clock);
    start = 1'b0;
    // Inputs after capture must not matter.
    mode = 3'($urandom_range(0, 7)); amount = AW'($urandom_range(0, 3));
    din = N'($urandom_range(0, 15));
    exp_q.push_back({exp_out, exp_c});
    check({name, "_out_after_capture"}, 32'(out_o), 32'(v));
    m_out = v; m_carry = 1'b0; m_cnt = int'(amt); edges = 0; busy_cycles = 0;
    while (!done_o && edges < 40) begin
      if (busy_o) busy_cycles++;
      check({name, "_trace_out"}, 32'(out_o), 32'(m_out));
      check({name, "_trace_carry"}, 32'(carry_o), 32'(m_carry));
      en    = !(edges >= stall_at && edges < stall_at + stall_len);
      start = (edges == poke_at);
      if (poke_at == edges) din = ~v;
      if (m_cnt != 0 && en) begin
        nxt = model_step(md, m_out);
        m_out = nxt[N:1]; m_carry = nxt[0]; m_cnt--;
      end
      @(negedge clock);
      edges++;
    end
    en = 1'b1; start = 1'b0;
    check({name, "_done_seen"}, 32'(done_o), 32'd1);
    check({name, "_busy_off_in_done"}, 32'(busy_o), 32'd0);
    check({name, "_latency"}, 32'(edges), 32'(exp_lat));
    check({name, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_lat));
    exp_r = exp_q.pop_front();
    check({name, "_final_out"}, 32'(out_o), 32'(exp_r[N:1]));
    check({name, "_final_carry"}, 32'(carry_o), 32'(exp_r[0]));
    @(negedge clock);
    check({name, "_done_pulse_len"}, 32'(done_o), 32'd0);
    check({name, "_idle_not_busy"}, 32'(busy_o), 32'd0);
    check({name, "_hold_out"}, 32'(out_o), 32'(exp_r[N:1]));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [N-1:0] rv;
    int ra;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("reset_out", 32'(out_o), 32'd0);
    check("reset_carry", 32'(carry_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    check("reset_state", 32'(state_o), 32'd0);
    reset = 1'b0;

    run_op("lsl", 3'b000, 2'd1, 4'b1010, 4'b0100, 1'b1, 2, -1, 0, -1);
    run_op("asr", 3'b010, 2'd3, 4'b1010, 4'b1111, 1'b0, 4, -1, 0, -1);
    run_op("rol", 3'b011, 2'd3, 4'b1001, 4'b1100, 1'b0, 4, -1, 0, -1);
    run_op("ror", 3'b100, 2'd1, 4'b1010, 4'b0101, 1'b0, 2, -1, 0, -1);
    run_op("lsr_stall", 3'b001, 2'd2, 4'b1000, 4'b0010, 1'b0, 6, 1, 3, -1);
    run_op("amt0", 3'b000, 2'd0, 4'b1011, 4'b1011, 1'b0, 1, -1, 0, -1);
    run_op("start_busy", 3'b011, 2'd3, 4'b1001, 4'b1100, 1'b0, 4, -1, 0, 1);
    run_op("reserved", 3'b101, 2'd2, 4'b0110, 4'b0110, 1'b0, 3, -1, 0, -1);
    // en low with count exhausted must not stall the exit.
    run_op("en_low_at_end", 3'b001, 2'd1, 4'b0011, 4'b0001, 1'b1, 2, 1, 5, -1);

    for (int i = 0; i < 3; i++) begin
      rv = N'($urandom_range(0, 15));
      ra = $urandom_range(1, 3);
      run_op("lsl_rand", 3'b000, AW'(ra), rv, N'(rv << ra), rv[N-ra], ra + 1, -1, 0, -1);
    end

    // Reset in the middle of SHIFT discards the operation.
    @(negedge clock);
    start = 1'b1; mode = 3'b000; amount = 2'd3; din = 4'b1111; en = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midreset_out", 32'(out_o), 32'd0);
    check("midreset_carry", 32'(carry_o), 32'd0);
    check("midreset_busy", 32'(busy_o), 32'd0);
    check("midreset_done", 32'(done_o), 32'd0);
    check("midreset_state", 32'(state_o), 32'd0);
    reset = 1'b0;
    run_op("after_reset", 3'b001, 2'd2, 4'b1100, 4'b0011, 1'b0, 3, -1, 0, -1);

    // ---------------------------------------------------------------- report
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Busy and done must never overlap.
  always @(negedge clock) begin
    if (busy_o && done_o) begin
      failures++;
      $error("FAIL busy_done_overlap observed=1 expected=0");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
